// File: rtl/sine_sequencer.sv
// Sine-burst phase sequencer: walks an 8-bit phase accumulator at a divided
// sample rate and emits quarter-wave LUT addresses plus a half-wave sign bit.
module sine_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] stepSel,
  input  logic [7:0] prescale,
  input  logic [3:0] periods,
  output logic [5:0] addr,
  output logic       signBit,
  output logic       sampleValid,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [7:0] div_q, div_d;
  logic [3:0] rem_q, rem_d;
  logic [1:0] step_sel_q, step_sel_d;
  logic [7:0] prescale_q, prescale_d;
  logic [3:0] periods_q, periods_d;
  logic [5:0] addr_q, addr_d;
  logic       sign_q, sign_d;
  logic       valid_q, valid_d;

  logic [7:0] step;
  logic [8:0] phase_sum;
  logic       finished;

  assign step      = 8'd1 << step_sel_q;
  assign phase_sum = {1'b0, phase_q} + {1'b0, step};
  // A finite burst has delivered its last sample once the period count hits 0.
  assign finished  = (periods_q != 4'd0) && (rem_q == 4'd0);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    div_d      = div_q;
    rem_d      = rem_q;
    step_sel_d = step_sel_q;
    prescale_d = prescale_q;
    periods_d  = periods_q;
    addr_d     = addr_q;
    sign_d     = sign_q;
    valid_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d    = S_RUN;
          step_sel_d = stepSel;
          prescale_d = prescale;
          periods_d  = periods;
          phase_d    = 8'd0;
          div_d      = prescale;
          rem_d      = periods;
        end
      end
      S_RUN: begin
        if (stop || finished) begin
          state_d = S_DONE;
        end else if (div_q == 8'd0) begin
          // Sample reflects the phase before this tick's increment.
          valid_d = 1'b1;
          addr_d  = phase_q[6] ? ~phase_q[5:0] : phase_q[5:0];
          sign_d  = phase_q[7];
          phase_d = phase_sum[7:0];
          div_d   = prescale_q;
          if (phase_sum[8] && (periods_q != 4'd0)) begin
            rem_d = rem_q - 4'd1;
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      phase_q    <= 8'd0;
      div_q      <= 8'd0;
      rem_q      <= 4'd0;
      step_sel_q <= 2'd0;
      prescale_q <= 8'd0;
      periods_q  <= 4'd0;
      addr_q     <= 6'd0;
      sign_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      step_sel_q <= step_sel_d;
      prescale_q <= prescale_d;
      periods_q  <= periods_d;
      addr_q     <= addr_d;
      sign_q     <= sign_d;
      valid_q    <= valid_d;
    end
  end

  assign addr        = addr_q;
  assign signBit     = sign_q;
  assign sampleValid = valid_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sine_sequencer.sv
// Self-checking bench for sine_sequencer: table-driven bursts with a sample
// scoreboard, plus hand-written stop, start/stop collision and reset sequences.
module tb_sine_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [1:0] stepSel;
  logic [7:0] prescale;
  logic [3:0] periods;
  logic [5:0] addr;
  logic       signBit;
  logic       sampleValid;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  sine_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .stepSel    (stepSel),
    .prescale   (prescale),
    .periods    (periods),
    .addr       (addr),
    .signBit    (signBit),
    .sampleValid(sampleValid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // Scoreboard: each entry is {signBit, addr} of an expected sample.
  logic [6:0] exp_q[$];
  logic [5:0] hold_addr;
  logic       hold_sign;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] pre;
    logic [3:0] per;
    int         exp_ticks;
    logic [5:0] exp_last_addr;
    logic       exp_last_sign;
    int         poke;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] model_addr(input logic [7:0] ph);
    return ph[6] ? ~ph[5:0] : ph[5:0];
  endfunction

  task automatic fill_expected(input logic [1:0] sel, input int n);
    logic [7:0] ph;
    ph = 8'd0;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({ph[7], model_addr(ph)});
      ph = ph + (8'd1 << sel);
    end
  endtask

  // Driver: one burst; poke >= 0 re-pulses start with a different stepSel mid-burst.
  task automatic run_burst(input vec_t v);
    int cyc;
    int last_tick;
    int ticks;
    logic [6:0] e;
    logic got_done;
    fill_expected(v.sel, v.exp_ticks);
    @(negedge clk);
    stepSel  = v.sel;
    prescale = v.pre;
    periods  = v.per;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on_entry", {31'd0, busy}, 32'd1);
    cyc = 0;
    last_tick = 0;
    ticks = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == v.poke) begin
        start   = 1'b1;
        stepSel = ~v.sel;
      end
      if (done) begin
        got_done = 1'b1;
      end else if (sampleValid) begin
        ticks++;
        check("tick_gap", cyc - last_tick, v.pre + 1);
        last_tick = cyc;
        if (exp_q.size() == 0) begin
          check("extra_sample", ticks, v.exp_ticks);
        end else begin
          e = exp_q.pop_front();
          check("sample_addr", {26'd0, addr}, {26'd0, e[5:0]});
          check("sample_sign", {31'd0, signBit}, {31'd0, e[6]});
          hold_addr = e[5:0];
          hold_sign = e[6];
        end
      end else begin
        check("addr_hold", {25'd0, signBit, addr}, {25'd0, hold_sign, hold_addr});
        check("busy_in_run", {31'd0, busy}, 32'd1);
      end
    end
    start = 1'b0;
    if (!got_done) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: got no done after %0d cycles, required done", cyc);
    end
    check("tick_count", ticks, v.exp_ticks);
    check("queue_drained", exp_q.size(), 0);
    check("last_addr", {26'd0, addr}, {26'd0, v.exp_last_addr});
    check("last_sign", {31'd0, signBit}, {31'd0, v.exp_last_sign});
    check("busy_in_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("state_idle", {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    logic [7:0] ph;
    int last_tick;
    errors   = 0;
    checks   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    stepSel  = 2'd0;
    prescale = 8'd0;
    periods  = 4'd0;
    hold_addr = 6'd0;
    hold_sign = 1'b0;

    //            sel    pre   per   ticks last   sign  poke
    vecs[0] = '{2'd0, 8'd0, 4'd1, 256, 6'd0, 1'b1, -1};
    vecs[1] = '{2'd3, 8'd3, 4'd2,  64, 6'd7, 1'b1, -1};
    vecs[2] = '{2'd1, 8'd1, 4'd1, 128, 6'd1, 1'b1, 20};
    vecs[3] = '{2'd2, 8'd0, 4'd3, 192, 6'd3, 1'b1, -1};
    vecs[4] = '{2'd3, 8'd0, 4'd1,  32, 6'd7, 1'b1,  5};

    #12;
    check("rst_addr", {26'd0, addr}, 32'd0);
    check("rst_sign", {31'd0, signBit}, 32'd0);
    check("rst_valid", {31'd0, sampleValid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i]);
    end

    // start and stop together in IDLE: stop wins
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("collide_busy", {31'd0, busy}, 32'd0);
      check("collide_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end

    // Continuous burst, aborted by stop after 1000 cycles
    stepSel  = 2'd2;
    prescale = 8'd2;
    periods  = 4'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ph = 8'd0;
    last_tick = 0;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      if (done) check("cont_no_done", {31'd0, done}, 32'd0);
      if (sampleValid) begin
        check("cont_gap", cyc - last_tick, 3);
        last_tick = cyc;
        check("cont_addr", {26'd0, addr}, {26'd0, model_addr(ph)});
        check("cont_sign", {31'd0, signBit}, {31'd0, ph[7]});
        hold_addr = model_addr(ph);
        hold_sign = ph[7];
        ph = ph + 8'd4;
      end
    end
    check("cont_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_done", {31'd0, done}, 32'd1);
    check("stop_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("stop_no_valid", {31'd0, sampleValid}, 32'd0);
      check("stop_no_done", {31'd0, done}, 32'd0);
    end
    check("stop_hold", {25'd0, signBit, addr}, {25'd0, hold_sign, hold_addr});

    // Asynchronous reset mid-burst
    stepSel  = 2'd0;
    prescale = 8'd1;
    periods  = 4'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (151) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_addr", {26'd0, addr}, 32'd0);
    check("arst_sign", {31'd0, signBit}, 32'd0);
    check("arst_valid", {31'd0, sampleValid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    hold_addr = 6'd0;
    hold_sign = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_done", {31'd0, done}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    run_burst(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
